inst_fetch: RTL and testbench

//  Instruction fetch stage upstream of the single-cycle core: samples the core's pc, fetches one
//  32-bit instruction over a req/gnt/rvalid memory port and presents it on cmd with a valid/ready

---
 rtl/inst_fetch_if.sv | 29 ++
 rtl/inst_fetch.sv | 119 +++++++++++
 tb/tb_inst_fetch.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: core-side pc/cmd handshake plus the req/gnt/rvalid instruction memory port.
// master = fetch unit, slave = core + memory side.
interface inst_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd;
  logic              cmd_valid;
  logic              fetch_fault;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_err;

  modport master (
    input  pc, cmd_ready, mem_gnt, mem_rvalid, mem_rdata, mem_err,
    output cmd, cmd_valid, fetch_fault, mem_req, mem_addr
  );

  modport slave (
    output pc, cmd_ready, mem_gnt, mem_rvalid, mem_rdata, mem_err,
    input  cmd, cmd_valid, fetch_fault, mem_req, mem_addr
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding word fetch per core handshake, faults become NOP.
// Optional WAIT-state watchdog enabled by defining IFU_TIMEOUT_EN.
module inst_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(32'h00000013)
`ifdef IFU_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] cmd_q;
  logic              valid_q;
  logic              fault_q;
  logic              rsp;

`ifdef IFU_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             drop_pend;

  // The first rvalid after a timeout belongs to the abandoned request.
  assign rsp = bus.mem_rvalid & ~drop_pend;
`else
  assign rsp = bus.mem_rvalid;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      cmd_q   <= NOP_INST;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
`ifdef IFU_TIMEOUT_EN
      tmo_cnt   <= '0;
      drop_pend <= 1'b0;
`endif
    end else begin
`ifdef IFU_TIMEOUT_EN
      tmo_cnt <= '0;
      if (bus.mem_rvalid && drop_pend) drop_pend <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          addr_q  <= {bus.pc[ADDR_W-1:2], 2'b00};
          fault_q <= 1'b0;
          if (bus.pc[1:0] != 2'b00) begin
            cmd_q   <= NOP_INST;
            fault_q <= 1'b1;
            valid_q <= 1'b1;
            state   <= VALID;
          end else begin
            state <= REQ;
          end
        end

        REQ: begin
          if (bus.mem_gnt) begin
            if (rsp) begin
              cmd_q   <= bus.mem_err ? NOP_INST : bus.mem_rdata;
              fault_q <= bus.mem_err;
              valid_q <= 1'b1;
              state   <= VALID;
            end else begin
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          if (rsp) begin
            cmd_q   <= bus.mem_err ? NOP_INST : bus.mem_rdata;
            fault_q <= bus.mem_err;
            valid_q <= 1'b1;
            state   <= VALID;
          end
`ifdef IFU_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            cmd_q     <= NOP_INST;
            fault_q   <= 1'b1;
            valid_q   <= 1'b1;
            drop_pend <= 1'b1;
            state     <= VALID;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        VALID: begin
          if (bus.cmd_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req     = (state == REQ);
  assign bus.mem_addr    = addr_q;
  assign bus.cmd         = cmd_q;
  assign bus.cmd_valid   = valid_q;
  assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed + randomized bench for inst_fetch; expected results come from the fetch rules
// (aligned & no error -> memory word, otherwise NOP with fault), not from the FSM.
`timescale 1ns/1ps
module tb_inst_fetch;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  inst_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  inst_fetch #(
    .ADDR_W(32),
    .DATA_W(32),
    .NOP_INST(NOP)
`ifdef IFU_TIMEOUT_EN
    , .TIMEOUT_CYC(8)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic quiet_mem();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_err    = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk1 ("rst_req",   bus.mem_req,     1'b0);
    chk32("rst_addr",  bus.mem_addr,    32'h0);
    chk32("rst_cmd",   bus.cmd,         NOP);
    chk1 ("rst_valid", bus.cmd_valid,   1'b0);
    chk1 ("rst_fault", bus.fetch_fault, 1'b0);
  endtask

  // One complete fetch starting in an IDLE cycle: g = cycles in REQ before gnt,
  // r = cycles from gnt to rvalid (0 = same cycle), hold = cycles cmd_ready stays low.
  task automatic do_fetch(input logic [31:0] p, input int g, input int r, input logic [31:0] d,
                          input logic e, input int hold, input bit stale);
    bit          mis;
    logic [31:0] exp_cmd;
    logic        exp_fault;
    mis       = (p[1:0] != 2'b00);
    exp_fault = mis || e;
    exp_cmd   = exp_fault ? NOP : d;

    bus.pc        = p;
    bus.cmd_ready = 1'b0;
    quiet_mem();
    chk1("idle_req",   bus.mem_req,   1'b0);
    chk1("idle_valid", bus.cmd_valid, 1'b0);
    tick();
    if (!mis) begin
      chk1("fault_clr", bus.fetch_fault, 1'b0);
      for (int i = 0; i < g; i++) begin
        chk1 ("req_pend",  bus.mem_req,  1'b1);
        chk32("addr_pend", bus.mem_addr, p);
        bus.mem_rvalid = stale && (i == 0);
        bus.mem_rdata  = $urandom;
        bus.mem_err    = 1'($urandom_range(0, 1));
        tick();
      end
      chk1 ("req_gnt",  bus.mem_req,  1'b1);
      chk32("addr_gnt", bus.mem_addr, p);
      bus.mem_gnt = 1'b1;
      if (r == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = d;
        bus.mem_err    = e;
      end else begin
        bus.mem_rvalid = 1'b0;
      end
      tick();
      quiet_mem();
      if (r > 0) begin
        for (int i = 1; i < r; i++) begin
          chk1("wait_req",   bus.mem_req,   1'b0);
          chk1("wait_valid", bus.cmd_valid, 1'b0);
          bus.mem_gnt = 1'($urandom_range(0, 1));
          tick();
        end
        chk1("wait_req", bus.mem_req, 1'b0);
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = d;
        bus.mem_err    = e;
        tick();
        quiet_mem();
      end
    end
    chk1 ("valid",       bus.cmd_valid,   1'b1);
    chk32("cmd",         bus.cmd,         exp_cmd);
    chk1 ("fault",       bus.fetch_fault, exp_fault);
    chk1 ("valid_req",   bus.mem_req,     1'b0);
    for (int i = 0; i < hold; i++) begin
      bus.mem_gnt    = 1'($urandom_range(0, 1));
      bus.mem_rvalid = 1'($urandom_range(0, 1));
      bus.mem_rdata  = $urandom;
      tick();
      chk1 ("hold_valid", bus.cmd_valid,   1'b1);
      chk32("hold_cmd",   bus.cmd,         exp_cmd);
      chk1 ("hold_fault", bus.fetch_fault, exp_fault);
      chk1 ("hold_req",   bus.mem_req,     1'b0);
    end
    quiet_mem();
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    chk1("hs_valid", bus.cmd_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rp;
    rst           = 1'b0;
    bus.pc        = 32'h8000_0000;
    bus.cmd_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    quiet_mem();
    repeat (3) tick();
    chk_reset_state();
    rst = 1'b1;

    // Zero-wait fetch, then VALID held for five cycles without cmd_ready.
    do_fetch(32'h8000_0000, 0, 0, 32'h0010_0093, 1'b0, 5, 1'b0);
    // Misaligned pc, then an aligned fetch clears the fault.
    do_fetch(32'h8000_0002, 0, 0, 32'h0, 1'b0, 1, 1'b0);
    do_fetch(32'h8000_0004, 0, 0, 32'h0020_0113, 1'b0, 0, 1'b0);
    // Delayed grant and delayed response.
    do_fetch(32'h8000_0008, 3, 2, 32'hFE01_0113, 1'b0, 2, 1'b0);
    // Bus error.
    do_fetch(32'h8000_000C, 1, 1, 32'h1234_5678, 1'b1, 1, 1'b0);

    // Reset while waiting for a response; the stale rvalid shows up before the next grant.
    bus.pc = 32'h8000_0010;
    tick();
    bus.mem_gnt = 1'b1;
    tick();
    quiet_mem();
    #2 rst = 1'b0;
    #1 chk_reset_state();
    tick();
    rst = 1'b1;
    do_fetch(32'h8000_0010, 2, 1, 32'h0030_0193, 1'b0, 0, 1'b1);

`ifdef IFU_TIMEOUT_EN
    bus.pc = 32'h8000_0100;
    tick();
    bus.mem_gnt = 1'b1;
    tick();
    quiet_mem();
    for (int i = 0; i < 8; i++) begin
      chk1("tmo_wait_valid", bus.cmd_valid, 1'b0);
      tick();
    end
    chk1 ("tmo_valid", bus.cmd_valid,   1'b1);
    chk32("tmo_cmd",   bus.cmd,         NOP);
    chk1 ("tmo_fault", bus.fetch_fault, 1'b1);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    bus.pc = 32'h8000_0104;
    tick();
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    tick();
    bus.mem_rvalid = 1'b0;
    chk1("late_drop", bus.cmd_valid, 1'b0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h00A0_0513;
    tick();
    quiet_mem();
    chk1 ("after_tmo_valid", bus.cmd_valid,   1'b1);
    chk32("after_tmo_cmd",   bus.cmd,         32'h00A0_0513);
    chk1 ("after_tmo_fault", bus.fetch_fault, 1'b0);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
`endif

    for (int k = 0; k < 40; k++) begin
      rp = $urandom;
      rp[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_fetch(rp, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
               1'($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)),
               $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
